// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads one word per instruction
// from instruction memory over a ready handshake, presents it to the IR with
// a one-cycle IRin strobe, then waits for the control unit to finish.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    output logic [31:0] MemAddr,
    output logic        MemRead,
    input  logic        MemReady,
    input  logic [31:0] MemData,
    output logic [31:0] InstrOut,
    output logic        IRin,
    input  logic        ExecDone,
    input  logic        PCwrite,
    input  logic [31:0] PCnew,
    output logic [31:0] PC,
    output logic        Halted,
    output logic        BusError,
    output logic [2:0]  FetchState
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [4:0]     HALT_OP  = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State, PC, instruction buffer and wait counter; Clear resets all at once.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: fetch handshake, timeout, halt decode and PC redirects.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (PCwrite) pc_d = PCnew;
                if (Run) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                // Ready in the last allowed cycle still wins over the timeout.
                if (MemReady) begin
                    buf_d   = MemData;
                    pc_d    = pc_q + 32'd1;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_ERROR;
                end
            end
            S_LOAD: begin
                state_d = (buf_q[31:27] == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // A redirect coinciding with ExecDone is what the next fetch uses.
                if (PCwrite) pc_d = PCnew;
                if (ExecDone) begin
                    if (Run) begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (PCwrite) pc_d = PCnew;
            end
            S_ERROR: begin
                // PC stays at the faulting address until Clear.
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state, so no input reaches an output.
    always_comb begin
        MemRead    = (state_q == S_REQ);
        MemAddr    = (state_q == S_REQ) ? pc_q : 32'h0;
        IRin       = (state_q == S_LOAD);
        Halted     = (state_q == S_HALT);
        BusError   = (state_q == S_ERROR);
        FetchState = state_q;
        PC         = pc_q;
        InstrOut   = buf_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a vector table, directed corner
// sequences, and a randomized run against a transaction-level PC/word model.
module tb_instr_fetch_unit;

    localparam int TO = 16;

    logic        Clock, Clear, Run, MemReady, ExecDone, PCwrite;
    logic [31:0] MemData, PCnew, MemAddr, InstrOut, PC;
    logic        MemRead, IRin, Halted, BusError;
    logic [2:0]  FetchState;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] start_pc;
        int          waits;
        logic [31:0] word;
        logic [2:0]  exp_state;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[6];

    instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run),
        .MemAddr(MemAddr), .MemRead(MemRead), .MemReady(MemReady), .MemData(MemData),
        .InstrOut(InstrOut), .IRin(IRin), .ExecDone(ExecDone),
        .PCwrite(PCwrite), .PCnew(PCnew), .PC(PC),
        .Halted(Halted), .BusError(BusError), .FetchState(FetchState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic quiet();
        Run = 0; MemReady = 0; MemData = 0; ExecDone = 0; PCwrite = 0; PCnew = 0;
    endtask

    task automatic do_reset();
        quiet();
        Clear = 0;
        step();
        step();
        Clear = 1;
    endtask

    // Called at a negedge where the DUT should be in REQ; returns at the LOAD negedge.
    task automatic serve(input int waits, input logic [31:0] word, input logic [31:0] addr,
                         input bit noise, input bit rand_run);
        int c;
        c = 0;
        chk("enter_req", 32'(FetchState), 32'd1);
        while (FetchState == 3'd1 && c <= waits + 2) begin
            chk("req_memread", 32'(MemRead), 32'd1);
            chk("req_memaddr", MemAddr, addr);
            MemReady = (c == waits);
            MemData  = (c == waits) ? word : $urandom;
            if (noise) begin PCwrite = 1; PCnew = 32'h0000_0099; end
            if (rand_run) Run = 1'($urandom_range(0, 1));
            c++;
            step();
        end
        MemReady = 0; PCwrite = 0;
        chk("req_cycles", 32'(c), 32'(waits + 1));
        chk("load_irin", 32'(IRin), 32'd1);
        chk("load_instr", InstrOut, word);
        chk("load_pc", PC, addr + 32'd1);
    endtask

    int          c, n;
    logic [31:0] mpc, word;
    bit          rn, pw;

    initial begin
        quiet();
        Clear = 1;
        // Asynchronous reset before any clock edge.
        #2 Clear = 0;
        #1;
        chk("rst_state", 32'(FetchState), 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", InstrOut, 32'h0);
        chk("rst_addr", MemAddr, 32'h0);
        chk("rst_flags", {28'h0, MemRead, IRin, Halted, BusError}, 32'h0);
        step();
        Clear = 1;

        // Vector table: start PC, wait cycles, word, state after LOAD, PC after capture.
        vecs[0] = '{32'h0000_0000,  0, 32'h1891_8000, 3'd3, 32'h0000_0001};
        vecs[1] = '{32'h0000_0005,  3, 32'h0123_4567, 3'd3, 32'h0000_0006};
        vecs[2] = '{32'h0000_0100,  0, 32'hD000_0000, 3'd3, 32'h0000_0101};
        vecs[3] = '{32'h0000_0200,  2, 32'hD800_0000, 3'd4, 32'h0000_0201};
        vecs[4] = '{32'hFFFF_FFFF,  1, 32'hDFFF_FFFF, 3'd4, 32'h0000_0000};
        vecs[5] = '{32'h0000_1000, 15, 32'hCAFE_F00D, 3'd3, 32'h0000_1001};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            PCwrite = 1; PCnew = vecs[i].start_pc;
            step();
            PCwrite = 0; Run = 1;
            step();
            serve(vecs[i].waits, vecs[i].word, vecs[i].start_pc, 0, 0);
            Run = 0;
            step();
            chk("vec_state", 32'(FetchState), 32'(vecs[i].exp_state));
            chk("vec_pc", PC, vecs[i].exp_pc);
            chk("vec_buserr", 32'(BusError), 32'd0);
        end

        // Zero-wait fetch, wait states, redirect, halt.
        do_reset();
        Run = 1;
        step();
        serve(0, 32'h1891_8000, 32'h0, 0, 0);
        step();
        chk("zw_exec", 32'(FetchState), 32'd3);
        chk("zw_irin_once", 32'(IRin), 32'd0);
        chk("zw_pc", PC, 32'h1);
        ExecDone = 1;
        step();
        ExecDone = 0;
        serve(3, 32'h0000_1111, 32'h1, 0, 0);
        chk("ws_buserr", 32'(BusError), 32'd0);
        PCwrite = 1; PCnew = 32'h77;
        step();
        chk("load_ignores_pcw", PC, 32'h2);
        PCwrite = 1; PCnew = 32'h40; ExecDone = 1;
        step();
        PCwrite = 0; ExecDone = 0;
        chk("redir_pc", PC, 32'h40);
        serve(1, 32'h2222_0000, 32'h40, 1, 0);
        step();
        ExecDone = 1;
        step();
        ExecDone = 0;
        serve(0, 32'hD800_0000, 32'h41, 0, 0);
        step();
        chk("halt_state", 32'(FetchState), 32'd4);
        chk("halt_flag", 32'(Halted), 32'd1);
        for (int k = 0; k < 20; k++) begin
            Run = 1'($urandom_range(0, 1));
            ExecDone = 1'($urandom_range(0, 1));
            MemReady = 1'($urandom_range(0, 1));
            step();
            chk("halt_memread", {30'h0, MemRead, IRin}, 32'h0);
            chk("halt_stay", 32'(Halted), 32'd1);
        end
        quiet();
        PCwrite = 1; PCnew = 32'h1234;
        step();
        PCwrite = 0;
        chk("halt_pcw", PC, 32'h1234);

        // Wrap and async reset mid-REQ.
        do_reset();
        PCwrite = 1; PCnew = 32'hFFFF_FFFF;
        step();
        PCwrite = 0;
        chk("idle_pcw", PC, 32'hFFFF_FFFF);
        Run = 1;
        step();
        serve(0, 32'h0BAD_0001, 32'hFFFF_FFFF, 0, 0);
        step();
        ExecDone = 1;
        step();
        ExecDone = 0;
        chk("wrap_req", 32'(FetchState), 32'd1);
        chk("wrap_addr", MemAddr, 32'h0);
        #2 Clear = 0;
        #1;
        chk("async_memread", 32'(MemRead), 32'd0);
        chk("async_state", 32'(FetchState), 32'd0);
        chk("async_pc", PC, 32'h0);
        chk("async_instr", InstrOut, 32'h0);
        MemReady = 1; MemData = 32'hFEED_BEEF;
        step();
        MemReady = 0;
        step();
        chk("late_ready_ignored", InstrOut, 32'h0);
        Clear = 1; Run = 0;
        step();
        chk("post_rst_idle", 32'(FetchState), 32'd0);

        // Timeout.
        do_reset();
        PCwrite = 1; PCnew = 32'h321;
        step();
        PCwrite = 0; Run = 1;
        step();
        c = 0;
        while (FetchState == 3'd1 && c < 40) begin
            MemReady = 0; MemData = $urandom;
            c++;
            step();
        end
        chk("to_cycles", 32'(c), 32'(TO));
        chk("to_state", 32'(FetchState), 32'd5);
        chk("to_buserr", 32'(BusError), 32'd1);
        chk("to_memread", 32'(MemRead), 32'd0);
        chk("to_pc", PC, 32'h321);
        MemReady = 1; PCwrite = 1; PCnew = 32'h5;
        repeat (3) step();
        chk("to_sticky", 32'(FetchState), 32'd5);
        chk("to_pc_frozen", PC, 32'h321);
        quiet();
        Clear = 0;
        #1;
        chk("to_clr_state", 32'(FetchState), 32'd0);
        chk("to_clr_flags", {28'h0, MemRead, IRin, Halted, BusError}, 32'h0);
        chk("to_clr_addr", MemAddr, 32'h0);
        step();
        Clear = 1;

        // Randomized run against a model that tracks only the PC and fetched words.
        do_reset();
        mpc = 32'h0;
        Run = 1;
        step();
        for (int i = 0; i < 150; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
            word = $urandom;
            if (word[31:27] == 5'b11011) word[27] = 1'b0;
            serve(c, word, mpc, 0, 1);
            mpc = mpc + 32'd1;
            step();
            chk("rnd_exec", 32'(FetchState), 32'd3);
            n = int'($urandom_range(0, 3));
            rn = ($urandom_range(0, 3) != 0);
            for (int k = 0; k <= n; k++) begin
                pw = ($urandom_range(0, 2) == 0);
                PCwrite = pw; PCnew = $urandom;
                ExecDone = (k == n);
                Run = (k == n) ? rn : 1'($urandom_range(0, 1));
                if (pw) mpc = PCnew;
                step();
                chk("rnd_exec_pc", PC, mpc);
            end
            PCwrite = 0; ExecDone = 0;
            if (!rn) begin
                chk("rnd_idle", 32'(FetchState), 32'd0);
                if ($urandom_range(0, 1) == 1) begin
                    PCwrite = 1; PCnew = $urandom; mpc = PCnew;
                    step();
                    PCwrite = 0;
                    chk("rnd_idle_pc", PC, mpc);
                end
                Run = 1;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
